// File: rtl/exe_muldiv_pkg.sv
// Shared types and helpers for the EX-stage RV64M multiply/divide unit.
// Package name `pipes` is kept so existing importers continue to compile.
package pipes;

    localparam int unsigned MULDIV_ITERS = 64;

    typedef enum logic [3:0] {
        MUL, MULH, MULHSU, MULHU,
        DIV, DIVU, REM, REMU,
        MULW, DIVW, DIVUW, REMW, REMUW
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } muldiv_state_t;

    function automatic logic op_is_mul(muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, MULHU, MULW};
    endfunction

    function automatic logic op_is_w(muldiv_op_t op);
        return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic op_is_rem(muldiv_op_t op);
        return op inside {REM, REMU, REMW, REMUW};
    endfunction

    function automatic logic op_a_signed(muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, MULW, DIV, REM, DIVW, REMW};
    endfunction

    function automatic logic op_b_signed(muldiv_op_t op);
        return op inside {MUL, MULH, MULW, DIV, REM, DIVW, REMW};
    endfunction

    // W ops see their low 32 bits widened to 64 bits: signed ops sign-extend,
    // unsigned ops zero-extend.
    function automatic logic [63:0] op_extend(muldiv_op_t op, logic [63:0] x);
        if (!op_is_w(op))
            return x;
        else if (op inside {MULW, DIVW, REMW})
            return {{32{x[31]}}, x[31:0]};
        else
            return {32'b0, x[31:0]};
    endfunction

    // W results are the low word sign-extended to 64 bits.
    function automatic logic [63:0] w_result(muldiv_op_t op, logic [63:0] x);
        return op_is_w(op) ? {{32{x[31]}}, x[31:0]} : x;
    endfunction

endpackage

// File: rtl/exe_muldiv_divider.sv
// Restoring divider core: unsigned magnitudes in, unsigned magnitudes out.
// One quotient bit per step; the post-step values are exposed
// combinationally so the caller can capture the final step directly.
module muldiv_divider #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            fits;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        rem_sh  = {rem, quo[XLEN-1]};
        diff    = rem_sh - {1'b0, dvs};
        fits    = ~diff[XLEN];
        rem_nxt = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nxt = {quo[XLEN-2:0], fits};
    end

    // Operand load and per-step update of quotient/remainder registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            quo <= quo_nxt;
            rem <= rem_nxt;
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// EX-stage RV64M multiply/divide unit: 64-step shift-add multiplier and
// restoring divider, with special cases resolved without iterating.
// Optional macro EXE_MULDIV_FAST_MUL_EN: single-cycle multiply.
module exe_muldiv
    import pipes::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic            flush,
    input  logic            Dwait,
    output logic            exe_is_waiting,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_t   state, state_nxt;
    logic [5:0]      cnt;
    logic            start;
    logic            load, step, res_we;
    logic [XLEN-1:0] res_nxt;

    logic [XLEN-1:0] ea, eb, ma, mb, sp_res, min_neg;
    logic            sa, sb, div_zero, div_ovf, special;

    muldiv_op_t      op_q;
    logic            sa_q, sb_q;
    logic [XLEN-1:0] mcand, mhi, mlo, mhi_nxt, mlo_nxt;
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] quo_nxt, rem_nxt;
    logic [XLEN-1:0] mul_res, div_res, q_fix, r_fix;

`ifdef EXE_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [XLEN-1:0]   fast_res;
`endif

    function automatic logic [XLEN-1:0] mul_pick(muldiv_op_t o, logic neg,
                                                 logic [2*XLEN-1:0] p);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return w_result(o, (o inside {MUL, MULW}) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN]);
    endfunction

    assign start = valid & ~flush & ~reset;
    assign done  = (state == DONE);

    // Operand widening, magnitudes and special-case detection on the raw inputs.
    always_comb begin
        ea       = op_extend(op, srca);
        eb       = op_extend(op, srcb);
        sa       = op_a_signed(op) & ea[XLEN-1];
        sb       = op_b_signed(op) & eb[XLEN-1];
        ma       = sa ? -ea : ea;
        mb       = sb ? -eb : eb;
        min_neg  = op_is_w(op) ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = ~op_is_mul(op) & (eb == '0);
        div_ovf  = ~op_is_mul(op) & op_a_signed(op) & (eb == '1) & (ea == min_neg);
        special  = div_zero | div_ovf;
        if (div_zero)
            sp_res = op_is_rem(op) ? ea : '1;
        else
            sp_res = op_is_rem(op) ? '0 : ea;
        sp_res   = w_result(op, sp_res);
    end

    // One shift-add multiply step; the post-step product feeds the final fix-up.
    always_comb begin
        mul_sum = {1'b0, mhi} + (mlo[0] ? {1'b0, mcand} : '0);
        mhi_nxt = mul_sum[XLEN:1];
        mlo_nxt = {mul_sum[0], mlo[XLEN-1:1]};
        mul_res = mul_pick(op_q, sa_q ^ sb_q, {mhi_nxt, mlo_nxt});
        q_fix   = (sa_q ^ sb_q) ? -quo_nxt : quo_nxt;
        r_fix   = sa_q ? -rem_nxt : rem_nxt;
        div_res = w_result(op_q, op_is_rem(op_q) ? r_fix : q_fix);
    end

`ifdef EXE_MULDIV_FAST_MUL_EN
    // Single-cycle product of the magnitudes, resolved straight from IDLE.
    always_comb begin
        fast_prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
        fast_res  = mul_pick(op, sa ^ sb, fast_prod);
    end
`endif

    // Next-state and handshake logic; flush and reset override everything.
    always_comb begin
        state_nxt      = state;
        exe_is_waiting = 1'b0;
        load           = 1'b0;
        step           = 1'b0;
        res_we         = 1'b0;
        res_nxt        = result;
        case (state)
            IDLE: begin
                if (start) begin
                    exe_is_waiting = 1'b1;
                    if (special) begin
                        res_we    = 1'b1;
                        res_nxt   = sp_res;
                        state_nxt = DONE;
                    end
`ifdef EXE_MULDIV_FAST_MUL_EN
                    else if (op_is_mul(op)) begin
                        res_we    = 1'b1;
                        res_nxt   = fast_res;
                        state_nxt = DONE;
                    end
`endif
                    else begin
                        load      = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    exe_is_waiting = 1'b1;
                    step           = 1'b1;
                    if (cnt == '0) begin
                        res_we    = 1'b1;
                        res_nxt   = op_is_mul(op_q) ? mul_res : div_res;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || !Dwait)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            state_nxt      = IDLE;
            exe_is_waiting = 1'b0;
            load           = 1'b0;
            step           = 1'b0;
            res_we         = 1'b0;
        end
    end

    // State, iteration counter, latched operands and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            op_q   <= MUL;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
            mcand  <= '0;
            mhi    <= '0;
            mlo    <= '0;
        end else begin
            state <= state_nxt;
            if (res_we)
                result <= res_nxt;
            if (load) begin
                cnt   <= 6'(MULDIV_ITERS - 1);
                op_q  <= op;
                sa_q  <= sa;
                sb_q  <= sb;
                mcand <= ma;
                mhi   <= '0;
                mlo   <= mb;
            end else if (step) begin
                if (cnt != '0)
                    cnt <= cnt - 6'd1;
                mhi <= mhi_nxt;
                mlo <= mlo_nxt;
            end
        end
    end

    muldiv_divider #(
        .XLEN(XLEN)
    ) u_divider (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .step     (step),
        .dividend (ma),
        .divisor  (mb),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed self-checking bench for exe_muldiv.
module tb_exe_muldiv;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset, valid, flush, Dwait;
    muldiv_op_t  op;
    logic [63:0] srca, srcb;
    logic        exe_is_waiting, done;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef EXE_MULDIV_FAST_MUL_EN
    localparam int MUL_DONE = 1;
`else
    localparam int MUL_DONE = 65;
`endif

    always #5 clk = ~clk;

    exe_muldiv #(.XLEN(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .op             (op),
        .srca           (srca),
        .srcb           (srcb),
        .flush          (flush),
        .Dwait          (Dwait),
        .exe_is_waiting (exe_is_waiting),
        .done           (done),
        .result         (result)
    );

    // Present one instruction to EX and hold it until done, then advance.
    task automatic run_op(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int waits, output int dcyc);
        res   = '0;
        waits = 0;
        dcyc  = -1;
        @(posedge clk); #1;
        op = o; srca = a; srcb = b; valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (exe_is_waiting) waits++;
            if (done) begin
                dcyc = c;
                res  = result;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 1'b1; flush = 1'b0; Dwait = 1'b0;
        op = DIVU; srca = 64'd5; srcb = 64'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exe_is_waiting !== 1'b0) begin
            n_fail++; $display("FAIL reset_wait: got %b want 0", exe_is_waiting);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b want 0", done);
        end
        n_checks++;
        if (result !== 64'd0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", result);
        end
        @(posedge clk); #1;
        reset = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (exe_is_waiting !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: wait=%b done=%b want 0 0", exe_is_waiting, done);
        end
    endtask

    task automatic test_mul();
        logic [63:0] r; int w, d;
        run_op(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            n_fail++; $display("FAIL mul_result: got %h want ffffffffffffffeb", r);
        end
        n_checks++;
        if (w !== MUL_DONE) begin
            n_fail++; $display("FAIL mul_wait_cycles: got %0d want %0d", w, MUL_DONE);
        end
        n_checks++;
        if (d !== MUL_DONE) begin
            n_fail++; $display("FAIL mul_done_cycle: got %0d want %0d", d, MUL_DONE);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || exe_is_waiting !== 1'b0) begin
            n_fail++; $display("FAIL mul_back_idle: done=%b wait=%b want 0 0", done, exe_is_waiting);
        end
    endtask

    task automatic test_mulh();
        logic [63:0] r; int w, d;
        run_op(MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++; $display("FAIL mulhu_result: got %h want fffffffffffffffe", r);
        end
        run_op(MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL mulhsu_result: got %h want ffffffffffffffff", r);
        end
        run_op(MULH, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL mulh_result: got %h want ffffffffffffffff", r);
        end
    endtask

    task automatic test_div_zero();
        logic [63:0] r; int w, d;
        run_op(DIVU, 64'd100, 64'd0, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL divu_by_zero: got %h want ffffffffffffffff", r);
        end
        n_checks++;
        if (w !== 1 || d !== 1) begin
            n_fail++; $display("FAIL divu_zero_timing: wait=%0d done_cyc=%0d want 1 1", w, d);
        end
        run_op(REM, 64'd100, 64'd0, r, w, d);
        n_checks++;
        if (r !== 64'd100) begin
            n_fail++; $display("FAIL rem_by_zero: got %h want 64", r);
        end
        n_checks++;
        if (w !== 1 || d !== 1) begin
            n_fail++; $display("FAIL rem_zero_timing: wait=%0d done_cyc=%0d want 1 1", w, d);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] r; int w, d;
        run_op(DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, w, d);
        n_checks++;
        if (r !== 64'h8000_0000_0000_0000 || d !== 1) begin
            n_fail++; $display("FAIL div_overflow: got %h cyc %0d want 8000000000000000 cyc 1", r, d);
        end
        run_op(REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, r, w, d);
        n_checks++;
        if (r !== 64'd0 || w !== 1) begin
            n_fail++; $display("FAIL rem_overflow: got %h wait %0d want 0 wait 1", r, w);
        end
    endtask

    task automatic test_divide();
        logic [63:0] r; int w, d;
        run_op(DIVW, 64'h0000_0000_FFFF_FFF9, 64'd2, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++; $display("FAIL divw_result: got %h want fffffffffffffffd", r);
        end
        n_checks++;
        if (d !== 65) begin
            n_fail++; $display("FAIL divw_done_cycle: got %0d want 65", d);
        end
        run_op(REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL remw_result: got %h want ffffffffffffffff", r);
        end
        run_op(DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, r, w, d);
        n_checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFF2) begin
            n_fail++; $display("FAIL div_neg_result: got %h want fffffffffffffff2", r);
        end
        run_op(REMU, 64'd1000, 64'd7, r, w, d);
        n_checks++;
        if (r !== 64'd6) begin
            n_fail++; $display("FAIL remu_result: got %h want 6", r);
        end
    endtask

    task automatic test_dwait();
        int dc;
        dc = -1;
        Dwait = 1'b1;
        @(posedge clk); #1;
        op = DIVU; srca = 64'd100; srcb = 64'd7; valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin dc = c; break; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dc !== 65) begin
            n_fail++; $display("FAIL dwait_done_cycle: got %0d want 65", dc);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) Dwait = 1'b0;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || exe_is_waiting !== 1'b0 || result !== 64'd14) begin
                n_fail++;
                $display("FAIL dwait_hold_%0d: done=%b wait=%b result=%h want 1 0 e", k, done, exe_is_waiting, result);
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || exe_is_waiting !== 1'b0) begin
            n_fail++; $display("FAIL dwait_release: done=%b wait=%b want 0 0", done, exe_is_waiting);
        end
    endtask

    task automatic test_flush();
        logic [63:0] r; int w, d; bit seen;
        @(posedge clk); #1;
        op = DIVU; srca = 64'd1000; srcb = 64'd3; valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (exe_is_waiting !== 1'b0) begin
            n_fail++; $display("FAIL flush_wait: got %b want 0", exe_is_waiting);
        end
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done || exe_is_waiting) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL flush_killed: activity seen=%b want 0", seen);
        end
        run_op(DIVU, 64'd9, 64'd4, r, w, d);
        n_checks++;
        if (r !== 64'd2 || w !== 65 || d !== 65) begin
            n_fail++; $display("FAIL after_flush_divu: got %h wait %0d cyc %0d want 2 65 65", r, w, d);
        end
    endtask

    task automatic test_reset_busy();
        bit seen;
        @(posedge clk); #1;
        op = DIVU; srca = 64'd1000; srcb = 64'd3; valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (exe_is_waiting !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_wait: got %b want 0", exe_is_waiting);
        end
        @(posedge clk); #1;
        reset = 1'b0; valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || result !== 64'd0) begin
            n_fail++; $display("FAIL reset_busy_state: done=%b result=%h want 0 0", done, result);
        end
        seen = 1'b0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy_no_done: seen=%b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div_zero();
        test_overflow();
        test_divide();
        test_dwait();
        test_flush();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
